lcd_debug_source: RTL

- Upstream feeder of the hex LCD driver. Produces the 8-bit address byte, 8-bit data byte and mode flag that the driver renders.
- Debounces three board push-buttons and steps a RAM browse address.
- Issues req/ack reads to the memory debug port and latches the result. In CPU mode it forwards the CPU program counter and accumulator instead.

---
 rtl/lcd_debug_source_if.sv | 10 +
 rtl/lcd_debug_source.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/lcd_debug_source_if.sv
// rtl/lcd_debug_source_if.sv - memory debug read port bundle (req/ack reads)
interface lcd_debug_source_if;
  logic [7:0] mem_addr;
  logic       mem_rd_req;
  logic       mem_rd_ack;
  logic [7:0] mem_rd_data;

  modport master (output mem_addr, output mem_rd_req, input mem_rd_ack, input mem_rd_data);
  modport slave  (input mem_addr, input mem_rd_req, output mem_rd_ack, output mem_rd_data);
endinterface

// File: rtl/lcd_debug_source.sv
// rtl/lcd_debug_source.sv - LCD debug feeder: button browse, RAM reads, CPU pass-through (optional AUTO_REPEAT_EN)
module lcd_debug_source #(
  parameter int DEBOUNCE_BITS = 16,
  parameter int REFRESH_BITS  = 20,
  parameter int RD_TIMEOUT    = 255
) (
  input  logic                qzt_clk,
  input  logic                reset,
  input  logic                btn_up,
  input  logic                btn_down,
  input  logic                btn_mode,
  input  logic [7:0]          cpu_pc,
  input  logic [7:0]          cpu_acc,
  lcd_debug_source_if.master  mem,
  output logic [7:0]          addr_out,
  output logic [7:0]          data_out,
  output logic                switch_flag,
  output logic                rd_timeout
);

  localparam int TO_W = (RD_TIMEOUT < 2) ? 1 : $clog2(RD_TIMEOUT + 1);
  localparam int B_UP = 0, B_DN = 1, B_MODE = 2;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

  logic [2:0]               sync1_q, sync2_q, stable_q, press_q;
  logic [DEBOUNCE_BITS-1:0] db_cnt_q [3];
  logic                     switch_q, trig_q, pend_q, req_q, rd_to_q;
  logic [7:0]               browse_q, mem_addr_q, addr_out_q, data_out_q;
  logic [REFRESH_BITS-1:0]  ref_cnt_q;
  logic [TO_W-1:0]          to_cnt_q;
  state_t                   state_q;
  logic                     rpt_up, rpt_down, step_up, step_down, mode_rise;

  // Two-flop synchronizers for the raw asynchronous buttons
  always_ff @(posedge qzt_clk) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= {btn_mode, btn_down, btn_up};
      sync2_q <= sync1_q;
    end
  end

  // Debounce: counter runs while the input disagrees with the accepted level
  always_ff @(posedge qzt_clk) begin
    if (reset) begin
      stable_q <= '0;
      press_q  <= '0;
      for (int i = 0; i < 3; i++) db_cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        press_q[i] <= 1'b0;
        if (sync2_q[i] == stable_q[i]) begin
          db_cnt_q[i] <= '0;
        end else if (&db_cnt_q[i]) begin
          stable_q[i] <= sync2_q[i];
          db_cnt_q[i] <= '0;
          press_q[i]  <= sync2_q[i];
        end else begin
          db_cnt_q[i] <= db_cnt_q[i] + 1'b1;
        end
      end
    end
  end

`ifdef AUTO_REPEAT_EN
  logic [DEBOUNCE_BITS+2:0] rpt_cnt_q;
  logic                     rpt_armed_q, rpt_q, held;

  assign held = switch_q & (stable_q[B_UP] ^ stable_q[B_DN]);

  // Auto-repeat: long initial delay, then a faster step cadence while held
  always_ff @(posedge qzt_clk) begin
    if (reset || !held) begin
      rpt_cnt_q   <= '0;
      rpt_armed_q <= 1'b0;
      rpt_q       <= 1'b0;
    end else begin
      rpt_q <= 1'b0;
      if (!rpt_armed_q && (&rpt_cnt_q)) begin
        rpt_q       <= 1'b1;
        rpt_armed_q <= 1'b1;
        rpt_cnt_q   <= '0;
      end else if (rpt_armed_q && (&rpt_cnt_q[DEBOUNCE_BITS:0])) begin
        rpt_q     <= 1'b1;
        rpt_cnt_q <= '0;
      end else begin
        rpt_cnt_q <= rpt_cnt_q + 1'b1;
      end
    end
  end

  assign rpt_up   = rpt_q & stable_q[B_UP] & ~stable_q[B_DN];
  assign rpt_down = rpt_q & stable_q[B_DN] & ~stable_q[B_UP];
`else
  assign rpt_up   = 1'b0;
  assign rpt_down = 1'b0;
`endif

  // Simultaneous up and down presses cancel; browsing only counts in RAM mode
  assign step_up   = switch_q & ((press_q[B_UP] & ~press_q[B_DN]) | rpt_up);
  assign step_down = switch_q & ((press_q[B_DN] & ~press_q[B_UP]) | rpt_down);
  assign mode_rise = press_q[B_MODE] & ~switch_q;

  // Mode flag, browse address, refresh timer and the collapsed read trigger
  always_ff @(posedge qzt_clk) begin
    if (reset) begin
      switch_q  <= 1'b0;
      browse_q  <= '0;
      ref_cnt_q <= '0;
      trig_q    <= 1'b0;
    end else begin
      ref_cnt_q <= ref_cnt_q + 1'b1;
      trig_q    <= mode_rise | step_up | step_down | (switch_q & (&ref_cnt_q));
      if (press_q[B_MODE]) switch_q <= ~switch_q;
      if (step_up)        browse_q <= browse_q + 8'd1;
      else if (step_down) browse_q <= browse_q - 8'd1;
    end
  end

  // Read FSM with registered request and LCD output latches
  always_ff @(posedge qzt_clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      mem_addr_q <= '0;
      req_q      <= 1'b0;
      to_cnt_q   <= '0;
      pend_q     <= 1'b0;
      addr_out_q <= '0;
      data_out_q <= '0;
      rd_to_q    <= 1'b0;
    end else begin
      if (!switch_q) begin
        addr_out_q <= cpu_pc;
        data_out_q <= cpu_acc;
      end
      case (state_q)
        S_IDLE: begin
          if (switch_q && (trig_q || pend_q)) begin
            mem_addr_q <= browse_q;
            pend_q     <= 1'b0;
            state_q    <= S_REQ;
          end
        end
        S_REQ: begin
          if (trig_q) pend_q <= 1'b1;
          req_q    <= 1'b1;
          to_cnt_q <= '0;
          state_q  <= S_WAIT;
        end
        S_WAIT: begin
          if (trig_q) pend_q <= 1'b1;
          if (mem.mem_rd_ack) begin
            if (switch_q) begin
              addr_out_q <= mem_addr_q;
              data_out_q <= mem.mem_rd_data;
              rd_to_q    <= 1'b0;
            end
            req_q   <= 1'b0;
            state_q <= S_IDLE;
          end else if (to_cnt_q == TO_W'(RD_TIMEOUT - 1)) begin
            if (switch_q) begin
              addr_out_q <= mem_addr_q;
              data_out_q <= 8'hFF;
              rd_to_q    <= 1'b1;
            end
            req_q   <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            to_cnt_q <= to_cnt_q + 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
      if (!switch_q) pend_q <= 1'b0;
    end
  end

  assign mem.mem_addr   = mem_addr_q;
  assign mem.mem_rd_req = req_q;
  assign addr_out       = addr_out_q;
  assign data_out       = data_out_q;
  assign switch_flag    = switch_q;
  assign rd_timeout     = rd_to_q;

endmodule
